// File: rtl/bp_cache_service_responder.sv
// ============================================================================
// Module   : bp_cache_service_responder
// Brief    : Single-request cache miss / uncached responder against a block
//            memory port. Optional watchdog: BP_CACHE_RESP_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_cache_service_responder #(
    parameter int paddr_width_p = 40,
    parameter int dword_width_p = 64,
    parameter int block_width_p = 512,
    parameter int sets_p        = 64,
    parameter int assoc_p       = 8,
    parameter int credits_p     = 2,
    localparam int index_w      = $clog2(sets_p),
    localparam int way_w        = $clog2(assoc_p),
    localparam int offset_w     = $clog2(block_width_p/8),
    localparam int tag_w        = paddr_width_p - index_w - offset_w,
    localparam int cred_w       = $clog2(credits_p+1)
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic [2+paddr_width_p+dword_width_p-1:0]    cache_req_i,
    input  logic                                        cache_req_v_i,
    output logic                                        cache_req_ready_o,
    input  logic [way_w:0]                              cache_req_metadata_i,
    input  logic                                        cache_req_metadata_v_i,
    output logic [2+index_w+way_w+block_width_p-1:0]    data_mem_pkt_o,
    output logic                                        data_mem_pkt_v_o,
    input  logic                                        data_mem_pkt_yumi_i,
    input  logic [block_width_p-1:0]                    data_mem_i,
    output logic [2+index_w+way_w+2+tag_w-1:0]          tag_mem_pkt_o,
    output logic                                        tag_mem_pkt_v_o,
    input  logic                                        tag_mem_pkt_yumi_i,
    input  logic [tag_w-1:0]                            tag_mem_i,
    output logic [index_w+way_w-1:0]                    stat_mem_pkt_o,
    output logic                                        stat_mem_pkt_v_o,
    input  logic                                        stat_mem_pkt_yumi_i,
    output logic                                        cache_req_complete_o,
    output logic                                        credits_full_o,
    output logic                                        credits_empty_o,
    output logic [2+paddr_width_p+block_width_p-1:0]    mem_cmd_o,
    output logic                                        mem_cmd_v_o,
    input  logic                                        mem_cmd_ready_i,
    input  logic [block_width_p-1:0]                    mem_resp_i,
    input  logic                                        mem_resp_v_i,
    output logic                                        mem_resp_yumi_o,
    output logic                                        error_o
);

    localparam logic [1:0] REQ_LOAD_MISS  = 2'd0;
    localparam logic [1:0] REQ_UC_LOAD    = 2'd2;
    localparam logic [1:0] DOP_READ       = 2'd0;
    localparam logic [1:0] DOP_WRITE      = 2'd1;
    localparam logic [1:0] DOP_UC_RET     = 2'd2;
    localparam logic [1:0] TOP_READ       = 2'd0;
    localparam logic [1:0] TOP_SET        = 2'd1;
    localparam logic [1:0] CMD_RD_BLOCK   = 2'd0;
    localparam logic [1:0] CMD_WR_BLOCK   = 2'd1;
    localparam logic [1:0] CMD_UC_RD      = 2'd2;
    localparam logic [1:0] CMD_UC_WR      = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_META, S_RD_DATA, S_RD_DATA_CAP, S_RD_TAG, S_RD_TAG_CAP,
        S_WB_CMD, S_FILL_CMD, S_FILL_RESP, S_WR_DATA, S_WR_TAG, S_CLR_STAT,
        S_UC_CMD, S_UC_RESP, S_UC_DATA, S_DONE
    } state_e;

    state_e                              state_q;
    logic [1:0]                          req_type_q;
    logic [paddr_width_p-1:0]            req_addr_q;
    logic [dword_width_p-1:0]            req_data_q;
    logic [way_w-1:0]                    meta_way_q;
    logic                                meta_dirty_q;
    logic                                meta_ok_q;
    logic [block_width_p-1:0]            wb_blk_q;
    logic                                pending_wb_ack_q;
    logic [cred_w-1:0]                   credits_q, credits_d;
    logic [2+index_w+way_w+block_width_p-1:0] data_pkt_q;
    logic                                data_v_q;
    logic [2+index_w+way_w+2+tag_w-1:0]  tag_pkt_q;
    logic                                tag_v_q;
    logic [index_w+way_w-1:0]            stat_pkt_q;
    logic                                stat_v_q;
    logic [2+paddr_width_p+block_width_p-1:0] cmd_q;
    logic                                cmd_v_q;

    logic [index_w-1:0]                  w_idx;
    logic [tag_w-1:0]                    w_tag;
    logic [paddr_width_p-1:0]            w_fill_addr;
    logic [way_w-1:0]                    w_way;
    logic                                w_dirty;
    logic                                w_meta_ok;
    logic                                w_cmd_hs;
    logic                                w_resp_hs;
    logic                                w_resp_state;
    logic [1:0]                          w_tag_state;

    assign w_idx        = req_addr_q[offset_w +: index_w];
    assign w_tag        = req_addr_q[paddr_width_p-1 -: tag_w];
    assign w_fill_addr  = {req_addr_q[paddr_width_p-1:offset_w], {offset_w{1'b0}}};
    // Metadata may arrive in the handshake cycle or any later cycle.
    assign w_meta_ok    = meta_ok_q | cache_req_metadata_v_i;
    assign w_way        = meta_ok_q ? meta_way_q   : cache_req_metadata_i[way_w:1];
    assign w_dirty      = meta_ok_q ? meta_dirty_q : cache_req_metadata_i[0];
    assign w_tag_state  = (req_type_q == REQ_LOAD_MISS) ? 2'b01 : 2'b10;

    assign credits_full_o   = (credits_q == cred_w'(credits_p));
    assign credits_empty_o  = (credits_q == '0);
    assign mem_cmd_v_o      = cmd_v_q & ~credits_full_o;
    assign w_cmd_hs         = mem_cmd_v_o & mem_cmd_ready_i;
    assign w_resp_state     = (state_q == S_FILL_RESP) || (state_q == S_UC_RESP);
    assign mem_resp_yumi_o  = mem_resp_v_i & w_resp_state & ~credits_empty_o;
    assign w_resp_hs        = mem_resp_yumi_o;

    assign cache_req_ready_o    = (state_q == S_IDLE);
    assign cache_req_complete_o = (state_q == S_DONE);
    assign data_mem_pkt_o       = data_pkt_q;
    assign data_mem_pkt_v_o     = data_v_q;
    assign tag_mem_pkt_o        = tag_pkt_q;
    assign tag_mem_pkt_v_o      = tag_v_q;
    assign stat_mem_pkt_o       = stat_pkt_q;
    assign stat_mem_pkt_v_o     = stat_v_q;
    assign mem_cmd_o            = cmd_q;

    always_comb begin
        credits_d = credits_q;
        if (w_cmd_hs && !w_resp_hs) begin
            credits_d = credits_q + cred_w'(1);
        end else if (!w_cmd_hs && w_resp_hs) begin
            credits_d = credits_q - cred_w'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= S_IDLE;
            req_type_q       <= '0;
            req_addr_q       <= '0;
            req_data_q       <= '0;
            meta_way_q       <= '0;
            meta_dirty_q     <= 1'b0;
            meta_ok_q        <= 1'b0;
            wb_blk_q         <= '0;
            pending_wb_ack_q <= 1'b0;
            credits_q        <= '0;
            data_pkt_q       <= '0;
            data_v_q         <= 1'b0;
            tag_pkt_q        <= '0;
            tag_v_q          <= 1'b0;
            stat_pkt_q       <= '0;
            stat_v_q         <= 1'b0;
            cmd_q            <= '0;
            cmd_v_q          <= 1'b0;
        end else begin
            credits_q <= credits_d;
            case (state_q)
                S_IDLE: begin
                    if (cache_req_v_i) begin
                        {req_type_q, req_addr_q, req_data_q} <= cache_req_i;
                        {meta_way_q, meta_dirty_q}           <= cache_req_metadata_i;
                        meta_ok_q                            <= cache_req_metadata_v_i;
                        state_q                              <= S_WAIT_META;
                    end
                end
                S_WAIT_META: begin
                    if (req_type_q[1]) begin
                        cmd_q   <= {(req_type_q == REQ_UC_LOAD) ? CMD_UC_RD : CMD_UC_WR, req_addr_q,
                                    {(block_width_p-dword_width_p){1'b0}}, req_data_q};
                        cmd_v_q <= 1'b1;
                        state_q <= S_UC_CMD;
                    end else if (w_meta_ok) begin
                        meta_way_q   <= w_way;
                        meta_dirty_q <= w_dirty;
                        meta_ok_q    <= 1'b1;
                        if (w_dirty) begin
                            data_pkt_q <= {DOP_READ, w_idx, w_way, {block_width_p{1'b0}}};
                            data_v_q   <= 1'b1;
                            state_q    <= S_RD_DATA;
                        end else begin
                            cmd_q   <= {CMD_RD_BLOCK, w_fill_addr, {block_width_p{1'b0}}};
                            cmd_v_q <= 1'b1;
                            state_q <= S_FILL_CMD;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (data_mem_pkt_yumi_i) begin
                        data_v_q <= 1'b0;
                        state_q  <= S_RD_DATA_CAP;
                    end
                end
                S_RD_DATA_CAP: begin
                    wb_blk_q  <= data_mem_i;
                    tag_pkt_q <= {TOP_READ, w_idx, meta_way_q, 2'b00, {tag_w{1'b0}}};
                    tag_v_q   <= 1'b1;
                    state_q   <= S_RD_TAG;
                end
                S_RD_TAG: begin
                    if (tag_mem_pkt_yumi_i) begin
                        tag_v_q <= 1'b0;
                        state_q <= S_RD_TAG_CAP;
                    end
                end
                S_RD_TAG_CAP: begin
                    cmd_q   <= {CMD_WR_BLOCK, tag_mem_i, w_idx, {offset_w{1'b0}}, wb_blk_q};
                    cmd_v_q <= 1'b1;
                    state_q <= S_WB_CMD;
                end
                S_WB_CMD: begin
                    // The fill command follows back-to-back; valid stays high.
                    if (w_cmd_hs) begin
                        pending_wb_ack_q <= 1'b1;
                        cmd_q            <= {CMD_RD_BLOCK, w_fill_addr, {block_width_p{1'b0}}};
                        state_q          <= S_FILL_CMD;
                    end
                end
                S_FILL_CMD: begin
                    if (w_cmd_hs) begin
                        cmd_v_q <= 1'b0;
                        state_q <= S_FILL_RESP;
                    end
                end
                S_FILL_RESP: begin
                    if (w_resp_hs) begin
                        if (pending_wb_ack_q) begin
                            pending_wb_ack_q <= 1'b0;
                        end else begin
                            data_pkt_q <= {DOP_WRITE, w_idx, meta_way_q, mem_resp_i};
                            data_v_q   <= 1'b1;
                            state_q    <= S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (data_mem_pkt_yumi_i) begin
                        data_v_q  <= 1'b0;
                        tag_pkt_q <= {TOP_SET, w_idx, meta_way_q, w_tag_state, w_tag};
                        tag_v_q   <= 1'b1;
                        state_q   <= S_WR_TAG;
                    end
                end
                S_WR_TAG: begin
                    if (tag_mem_pkt_yumi_i) begin
                        tag_v_q    <= 1'b0;
                        stat_pkt_q <= {w_idx, meta_way_q};
                        stat_v_q   <= 1'b1;
                        state_q    <= S_CLR_STAT;
                    end
                end
                S_CLR_STAT: begin
                    if (stat_mem_pkt_yumi_i) begin
                        stat_v_q <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_UC_CMD: begin
                    if (w_cmd_hs) begin
                        cmd_v_q <= 1'b0;
                        state_q <= S_UC_RESP;
                    end
                end
                S_UC_RESP: begin
                    if (w_resp_hs) begin
                        if (req_type_q == REQ_UC_LOAD) begin
                            data_pkt_q <= {DOP_UC_RET, w_idx, {way_w{1'b0}},
                                           {(block_width_p-dword_width_p){1'b0}},
                                           mem_resp_i[dword_width_p-1:0]};
                            data_v_q   <= 1'b1;
                            state_q    <= S_UC_DATA;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_UC_DATA: begin
                    if (data_mem_pkt_yumi_i) begin
                        data_v_q <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    meta_ok_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BP_CACHE_RESP_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
    logic        error_q;

    always_comb begin
        wdog_d = wdog_q;
        if (mem_resp_v_i || (state_q == S_IDLE)) begin
            wdog_d = '0;
        end else if (w_resp_state && (wdog_q != 16'hFFFF)) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    // error_q is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            if (wdog_q == 16'hFFFF) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_cache_service_responder.sv
// ============================================================================
// Module   : tb_bp_cache_service_responder
// Brief    : Self-checking bench for bp_cache_service_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bp_cache_service_responder;

    localparam int PA = 40, DW = 64, BW = 512, IW = 6, WW = 3, TW = 28;
    localparam int CREDITS = 2;
    localparam int LIMIT = 300;
`ifdef BP_CACHE_RESP_TIMEOUT_EN
    localparam int   STALL   = 65540;
    localparam logic EXP_ERR = 1'b1;
`else
    localparam int   STALL   = 200;
    localparam logic EXP_ERR = 1'b0;
`endif

    localparam logic [599:0] M_ALL     = {600{1'b1}};
    localparam logic [599:0] M_DOPIW   = {77'd0, 11'h7FF, 512'd0};
    localparam logic [599:0] M_DOPDATA = {77'd0, 2'b11, 9'd0, {512{1'b1}}};
    localparam logic [599:0] M_TOPIW   = {559'd0, 11'h7FF, 30'd0};
    localparam logic [599:0] M_CMDHDR  = {46'd0, 42'h3FF_FFFF_FFFF, 512'd0};

    logic                   clk = 1'b0;
    logic                   reset_i;
    logic [2+PA+DW-1:0]     cache_req_i;
    logic                   cache_req_v_i, cache_req_ready_o;
    logic [WW:0]            cache_req_metadata_i;
    logic                   cache_req_metadata_v_i;
    logic [2+IW+WW+BW-1:0]  data_mem_pkt_o;
    logic                   data_mem_pkt_v_o, data_mem_pkt_yumi_i;
    logic [BW-1:0]          data_mem_i;
    logic [2+IW+WW+2+TW-1:0] tag_mem_pkt_o;
    logic                   tag_mem_pkt_v_o, tag_mem_pkt_yumi_i;
    logic [TW-1:0]          tag_mem_i;
    logic [IW+WW-1:0]       stat_mem_pkt_o;
    logic                   stat_mem_pkt_v_o, stat_mem_pkt_yumi_i;
    logic                   cache_req_complete_o, credits_full_o, credits_empty_o;
    logic [2+PA+BW-1:0]     mem_cmd_o;
    logic                   mem_cmd_v_o, mem_cmd_ready_i;
    logic [BW-1:0]          mem_resp_i;
    logic                   mem_resp_v_i, mem_resp_yumi_o, error_o;

    int errors = 0, checks = 0;
    int tag_cnt = 0, stat_cnt = 0, cmp_cnt = 0;

    bp_cache_service_responder dut (
        .clk_i(clk), .reset_i(reset_i),
        .cache_req_i(cache_req_i), .cache_req_v_i(cache_req_v_i), .cache_req_ready_o(cache_req_ready_o),
        .cache_req_metadata_i(cache_req_metadata_i), .cache_req_metadata_v_i(cache_req_metadata_v_i),
        .data_mem_pkt_o(data_mem_pkt_o), .data_mem_pkt_v_o(data_mem_pkt_v_o),
        .data_mem_pkt_yumi_i(data_mem_pkt_yumi_i), .data_mem_i(data_mem_i),
        .tag_mem_pkt_o(tag_mem_pkt_o), .tag_mem_pkt_v_o(tag_mem_pkt_v_o),
        .tag_mem_pkt_yumi_i(tag_mem_pkt_yumi_i), .tag_mem_i(tag_mem_i),
        .stat_mem_pkt_o(stat_mem_pkt_o), .stat_mem_pkt_v_o(stat_mem_pkt_v_o),
        .stat_mem_pkt_yumi_i(stat_mem_pkt_yumi_i),
        .cache_req_complete_o(cache_req_complete_o),
        .credits_full_o(credits_full_o), .credits_empty_o(credits_empty_o),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tag_mem_pkt_v_o)      tag_cnt++;
        if (stat_mem_pkt_v_o)     stat_cnt++;
        if (cache_req_complete_o) cmp_cnt++;
    end

    task automatic chk(input logic [599:0] obs, input logic [599:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Channel 0 data, 1 tag, 2 stat, 3 mem_cmd; bit 600 is valid.
    function automatic logic [600:0] smp(input int ch);
        logic [600:0] r;
        r = '0;
        case (ch)
            0:       begin r[600] = data_mem_pkt_v_o; r[522:0] = data_mem_pkt_o; end
            1:       begin r[600] = tag_mem_pkt_v_o;  r[40:0]  = tag_mem_pkt_o;  end
            2:       begin r[600] = stat_mem_pkt_v_o; r[8:0]   = stat_mem_pkt_o; end
            default: begin r[600] = mem_cmd_v_o;      r[553:0] = mem_cmd_o;      end
        endcase
        return r;
    endfunction

    task automatic set_y(input int ch, input logic v);
        case (ch)
            0:       data_mem_pkt_yumi_i = v;
            1:       tag_mem_pkt_yumi_i  = v;
            2:       stat_mem_pkt_yumi_i = v;
            default: mem_cmd_ready_i     = v;
        endcase
    endtask

    task automatic xfer(input int ch, input logic [599:0] exp, input logic [599:0] mask,
                        input int dly, input string tag);
        logic [600:0] s;
        int n = 0;
        s = smp(ch);
        while (!s[600] && n < LIMIT) begin @(negedge clk); s = smp(ch); n++; end
        chk(s[600], 1'b1, {tag, "_valid"});
        chk(s[599:0] & mask, exp & mask, tag);
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            s = smp(ch);
            chk({s[600], s[599:0] & mask}, {1'b1, exp & mask}, {tag, "_stable"});
        end
        set_y(ch, 1'b1);
        @(negedge clk);
        set_y(ch, 1'b0);
    endtask

    task automatic resp(input logic [511:0] d, input int dly, input string tag);
        int n = 0;
        repeat (dly) @(negedge clk);
        mem_resp_i = d; mem_resp_v_i = 1'b1;
        #1;
        while (!mem_resp_yumi_o && n < LIMIT) begin @(negedge clk); #1; n++; end
        chk(mem_resp_yumi_o, 1'b1, {tag, "_yumi"});
        @(negedge clk);
        mem_resp_v_i = 1'b0; mem_resp_i = rand512();
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    // abort: 0 normal, 1 reset while waiting for the fill, 2 stall the uncached response.
    task automatic run_req(input logic [1:0] ty, input logic [39:0] addr, input logic [63:0] wd,
                           input logic [2:0] way, input logic dirty, input int md, input int yd,
                           input int cd, input logic [27:0] t, input logic [511:0] f,
                           input int abort, input string nm);
        logic [5:0]   idx;
        logic [27:0]  tg;
        logic [39:0]  base, wb_addr;
        logic [511:0] b;
        int tag_c0, stat_c0, cmp_c0, n, outstanding;
        idx     = 6'((addr / 64) % 64);
        tg      = 28'(addr / 4096);
        base    = addr - (addr % 64);
        wb_addr = 40'(t) * 4096 + 40'(idx) * 64;
        b       = rand512();
        tag_c0 = tag_cnt; stat_c0 = stat_cnt; cmp_c0 = cmp_cnt;

        cache_req_i   = {ty, addr, wd};
        cache_req_v_i = 1'b1;
        if (!ty[1] && md == 0) begin
            cache_req_metadata_i = {way, dirty}; cache_req_metadata_v_i = 1'b1;
        end
        #1 chk(cache_req_ready_o, 1'b1, {nm, "_ready"});
        @(negedge clk);
        cache_req_v_i = 1'b0; cache_req_metadata_v_i = 1'b0;
        cache_req_i = {$urandom, $urandom, $urandom, $urandom};
        if (!ty[1] && md > 0) begin
            repeat (md - 1) @(negedge clk);
            chk({cache_req_ready_o, data_mem_pkt_v_o, mem_cmd_v_o}, 3'b000, {nm, "_waitmeta"});
            cache_req_metadata_i = {way, dirty}; cache_req_metadata_v_i = 1'b1;
            @(negedge clk);
            cache_req_metadata_v_i = 1'b0; cache_req_metadata_i = 4'($urandom);
        end

        if (ty[1]) begin
            xfer(3, {(ty == 2'd2) ? 2'd2 : 2'd3, addr, 448'd0, wd}, M_ALL, cd, {nm, "_uccmd"});
            if (abort == 2) begin
                repeat (STALL) @(negedge clk);
                chk(error_o, EXP_ERR, {nm, "_timeout"});
                repeat (20) @(negedge clk);
                chk(error_o, EXP_ERR, {nm, "_sticky"});
                pulse_reset();
                chk({error_o, cache_req_ready_o, credits_empty_o}, 3'b011, {nm, "_rst"});
                return;
            end
            resp(f, yd, {nm, "_ucresp"});
            if (ty == 2'd2)
                xfer(0, {2'd2, 9'd0, 448'd0, f[63:0]}, M_DOPDATA, yd, {nm, "_ucdata"});
        end else begin
            if (dirty) begin
                xfer(0, {2'd0, idx, way, 512'd0}, M_DOPIW, yd, {nm, "_rddata"});
                data_mem_i = b;
                @(negedge clk);
                data_mem_i = rand512();
                xfer(1, {2'd0, idx, way, 30'd0}, M_TOPIW, yd, {nm, "_rdtag"});
                tag_mem_i = t;
                @(negedge clk);
                tag_mem_i = 28'($urandom);
                xfer(3, {2'd1, wb_addr, b}, M_ALL, cd, {nm, "_wbcmd"});
            end
            xfer(3, {2'd0, base, 512'd0}, M_CMDHDR, cd, {nm, "_fillcmd"});
            outstanding = dirty ? 2 : 1;
            chk({credits_full_o, credits_empty_o, mem_cmd_v_o},
                {outstanding == CREDITS, 1'b0, 1'b0}, {nm, "_credits"});
            if (abort == 1) begin
                pulse_reset();
                chk({cache_req_ready_o, data_mem_pkt_v_o, tag_mem_pkt_v_o, stat_mem_pkt_v_o,
                     mem_cmd_v_o, cache_req_complete_o, mem_resp_yumi_o, credits_empty_o,
                     credits_full_o, error_o}, 10'b1000000100, {nm, "_rst"});
                return;
            end
            if (dirty) resp(rand512(), yd, {nm, "_wback"});
            resp(f, yd, {nm, "_fill"});
            xfer(0, {2'd1, idx, way, f}, M_ALL, yd, {nm, "_wrdata"});
            xfer(1, {2'd1, idx, way, (ty == 2'd0) ? 2'b01 : 2'b10, tg}, M_ALL, yd, {nm, "_wrtag"});
            xfer(2, {idx, way}, M_ALL, yd, {nm, "_stat"});
        end

        n = 0;
        while (!cache_req_complete_o && n < LIMIT) begin @(negedge clk); n++; end
        chk(cache_req_complete_o, 1'b1, {nm, "_done"});
        @(negedge clk);
        chk({cache_req_complete_o, cache_req_ready_o, credits_empty_o}, 3'b011, {nm, "_idle"});
        chk(cmp_cnt - cmp_c0, 1, {nm, "_pulses"});
        if (ty[1]) chk({tag_cnt - tag_c0, stat_cnt - stat_c0}, 64'd0, {nm, "_nometa"});
    endtask

    initial begin
        logic [1:0]  ty;
        logic [39:0] addr;
        reset_i = 1'b1;
        cache_req_i = '0; cache_req_v_i = 1'b0;
        cache_req_metadata_i = '0; cache_req_metadata_v_i = 1'b0;
        data_mem_pkt_yumi_i = 1'b0; tag_mem_pkt_yumi_i = 1'b0; stat_mem_pkt_yumi_i = 1'b0;
        data_mem_i = '0; tag_mem_i = '0;
        mem_cmd_ready_i = 1'b0; mem_resp_i = '0; mem_resp_v_i = 1'b0;
        repeat (3) @(negedge clk);
        chk({cache_req_ready_o, data_mem_pkt_v_o, tag_mem_pkt_v_o, stat_mem_pkt_v_o, mem_cmd_v_o,
             cache_req_complete_o, mem_resp_yumi_o, credits_empty_o, credits_full_o, error_o},
            10'b1000000100, "reset");
        reset_i = 1'b0;
        @(negedge clk);

        run_req(2'd0, 40'h80001040, 64'h0, 3'd3, 1'b0, 0, 0, 0, 28'd0, {64{8'hA5}}, 0, "clean_ld");
        run_req(2'd1, 40'h12345680, 64'h0, 3'd5, 1'b1, 1, 0, 0, 28'h1234, rand512(), 0, "dirty_st");
        run_req(2'd2, 40'h00100008, 64'h0, 3'd0, 1'b0, 0, 0, 0, 28'd0,
                {448'd0, 64'h00000000DEADBEEF}, 0, "uc_ld");
        run_req(2'd1, 40'h0ABCDEF40, 64'h0, 3'd6, 1'b1, 2, 3, 10, 28'h0BEEF, rand512(), 0, "bkpr");
        run_req(2'd0, 40'h00004000, 64'h0, 3'd1, 1'b0, 0, 2, 0, 28'd0, rand512(), 1, "rst_fill");

        for (int i = 0; i < 16; i++) begin
            ty   = 2'($urandom_range(0, 3));
            addr = {8'($urandom), 32'($urandom)};
            run_req(ty, addr, {$urandom, $urandom}, 3'($urandom), 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    28'($urandom), rand512(), 0, "rnd");
        end

        run_req(2'd2, 40'h00200010, 64'h0, 3'd0, 1'b0, 0, 0, 0, 28'd0, rand512(), 2, "wdog");
        run_req(2'd3, 40'h00300018, 64'h1122334455667788, 3'd0, 1'b0, 0, 1, 1, 28'd0,
                rand512(), 0, "uc_st");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
